mmc1_serial_regs: RTL and testbench

- Behavioural, single-clock model of the MMC1 CPU-side serial load port, its four 5-bit internal registers, and the PRG/CHR/CIRAM bank outputs derived from them.
- Sits directly upstream of the MMC1 banking outputs. It is the functional counterpart the team runs side by side with the gate-level MMC1 netlist built from the mmc1_* cells, with outputs compared cycle by cycle.
- Consumes CPU write events that are already synchronised to ck.

---
 rtl/mmc1_serial_regs.sv | 122 ++++++++++++
 tb/tb_mmc1_serial_regs.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_serial_regs.sv
// mmc1_serial_regs: behavioural model of the MMC1 CPU-side serial load port,
// its four 5-bit internal registers and the PRG/CHR/CIRAM bank mapping.
// Serial bits arrive LSB first on cpu_d0; the fifth write commits the
// assembled value to the register selected by {cpu_a14, cpu_a13}.
module mmc1_serial_regs #(
   parameter logic       IGNORE_CONSECUTIVE = 1'b1,
   parameter logic [4:0] CTRL_RESET         = 5'b01100
) (
   input  logic       ck,
   input  logic       res,
   input  logic       cpu_wr,
   input  logic       cyc_end,
   input  logic       cpu_a14,
   input  logic       cpu_a13,
   input  logic       cpu_d7,
   input  logic       cpu_d0,
   input  logic       ppu_a10,
   input  logic       ppu_a11,
   input  logic       ppu_a12,
   output logic [3:0] prg_a,
   output logic [4:0] chr_a,
   output logic       cira10,
   output logic       prg_ram_ce_n,
   output logic [4:0] ctrl,
   output logic [4:0] chr0,
   output logic [4:0] chr1,
   output logic [4:0] prg
);

   logic [3:0] shift_r;
   logic [2:0] count_r;
   logic       cur_wr_r;
   logic       last_wr_r;
   logic [4:0] ctrl_r;
   logic [4:0] chr0_r;
   logic [4:0] chr1_r;
   logic [4:0] prg_r;

   logic       drop_s;
   logic [4:0] value_s;

   // A serial bit is dropped when it lands in the CPU cycle right after a write cycle
   assign drop_s  = IGNORE_CONSECUTIVE & last_wr_r;
   assign value_s = {cpu_d0, shift_r};

   // Serial shifter, bit counter, consecutive-write tracking and register commit
   always_ff @(posedge ck or posedge res) begin
      if (res) begin
         shift_r   <= 4'b0000;
         count_r   <= 3'd0;
         cur_wr_r  <= 1'b0;
         last_wr_r <= 1'b0;
         ctrl_r    <= CTRL_RESET;
         chr0_r    <= 5'b00000;
         chr1_r    <= 5'b00000;
         prg_r     <= 5'b00000;
      end else begin
         if (cpu_wr) begin
            cur_wr_r <= 1'b1;
            if (cpu_d7) begin
               // Reset write: clear the load and force PRG mode 3, keep the rest of ctrl
               shift_r     <= 4'b0000;
               count_r     <= 3'd0;
               ctrl_r[3:2] <= 2'b11;
            end else if (!drop_s) begin
               if (count_r == 3'd4) begin
                  case ({cpu_a14, cpu_a13})
                     2'b00:   ctrl_r <= value_s;
                     2'b01:   chr0_r <= value_s;
                     2'b10:   chr1_r <= value_s;
                     2'b11:   prg_r  <= value_s;
                     default: prg_r  <= prg_r;
                  endcase
                  shift_r <= 4'b0000;
                  count_r <= 3'd0;
               end else begin
                  shift_r <= {cpu_d0, shift_r[3:1]};
                  count_r <= count_r + 3'd1;
               end
            end
         end else if (cyc_end) begin
            last_wr_r <= cur_wr_r;
            cur_wr_r  <= 1'b0;
         end
      end
   end

   // Bank mapping from the registers and the live CPU/PPU address lines
   always_comb begin
      prg_a  = 4'h0;
      chr_a  = 5'h00;
      cira10 = 1'b0;

      case (ctrl_r[1:0])
         2'd0:    cira10 = 1'b0;
         2'd1:    cira10 = 1'b1;
         2'd2:    cira10 = ppu_a10;
         2'd3:    cira10 = ppu_a11;
         default: cira10 = 1'b0;
      endcase

      case (ctrl_r[3:2])
         2'd0, 2'd1: prg_a = {prg_r[3:1], cpu_a14};
         2'd2:       prg_a = cpu_a14 ? prg_r[3:0] : 4'h0;
         2'd3:       prg_a = cpu_a14 ? 4'hF : prg_r[3:0];
         default:    prg_a = 4'h0;
      endcase

      if (ctrl_r[4]) begin
         chr_a = ppu_a12 ? chr1_r : chr0_r;
      end else begin
         chr_a = {chr0_r[4:1], ppu_a12};
      end
   end

   assign prg_ram_ce_n = prg_r[4];
   assign ctrl         = ctrl_r;
   assign chr0         = chr0_r;
   assign chr1         = chr1_r;
   assign prg          = prg_r;

endmodule

// File: tb/tb_mmc1_serial_regs.sv
// tb_mmc1_serial_regs: table-driven mapping vectors plus hand-written serial
// sequences. Expected output bundles go into a scoreboard queue when inputs
// are driven and are popped and compared on the following falling edge.
// A second instance with IGNORE_CONSECUTIVE=0 shares all inputs.
module tb_mmc1_serial_regs;

   logic ck = 1'b0;
   logic res, cpu_wr, cyc_end, cpu_a14, cpu_a13, cpu_d7, cpu_d0;
   logic ppu_a10, ppu_a11, ppu_a12;

   logic [3:0] prg_a, prg_a0;
   logic [4:0] chr_a, chr_a0;
   logic       cira10, cira100, ce_n, ce_n0;
   logic [4:0] ctrl, chr0, chr1, prg, ctrl0, chr00, chr10, prg0;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string      name;
      logic [3:0] prg_a;
      logic [4:0] chr_a;
      logic       cira;
      logic       ce;
      logic [4:0] ctrl, chr0, chr1, prg;
      logic [4:0] prg0;
      bit         same0;
   } exp_t;

   typedef struct {
      logic [4:0] ctrl, chr0, chr1, prg;
      logic       a14, p10, p11, p12;
      logic [3:0] e_prg_a;
      logic [4:0] e_chr_a;
      logic       e_cira, e_ce;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];

   mmc1_serial_regs #(.IGNORE_CONSECUTIVE(1'b1), .CTRL_RESET(5'b01100)) dut (
      .ck(ck), .res(res), .cpu_wr(cpu_wr), .cyc_end(cyc_end),
      .cpu_a14(cpu_a14), .cpu_a13(cpu_a13), .cpu_d7(cpu_d7), .cpu_d0(cpu_d0),
      .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .ppu_a12(ppu_a12),
      .prg_a(prg_a), .chr_a(chr_a), .cira10(cira10), .prg_ram_ce_n(ce_n),
      .ctrl(ctrl), .chr0(chr0), .chr1(chr1), .prg(prg)
   );

   mmc1_serial_regs #(.IGNORE_CONSECUTIVE(1'b0), .CTRL_RESET(5'b01100)) dut0 (
      .ck(ck), .res(res), .cpu_wr(cpu_wr), .cyc_end(cyc_end),
      .cpu_a14(cpu_a14), .cpu_a13(cpu_a13), .cpu_d7(cpu_d7), .cpu_d0(cpu_d0),
      .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .ppu_a12(ppu_a12),
      .prg_a(prg_a0), .chr_a(chr_a0), .cira10(cira100), .prg_ram_ce_n(ce_n0),
      .ctrl(ctrl0), .chr0(chr00), .chr1(chr10), .prg(prg0)
   );

   // Free-running clock, 10 time units per period
   always #5 ck = ~ck;

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Push the expectation, then pop and compare once the DUT has settled
   task automatic expect_out(input exp_t e);
      exp_t g;
      sb.push_back(e);
      @(negedge ck);
      g = sb.pop_front();
      chk({g.name, ".prg_a"},  {4'h0, prg_a},  {4'h0, g.prg_a});
      chk({g.name, ".chr_a"},  {3'h0, chr_a},  {3'h0, g.chr_a});
      chk({g.name, ".cira10"}, {7'h0, cira10}, {7'h0, g.cira});
      chk({g.name, ".ce_n"},   {7'h0, ce_n},   {7'h0, g.ce});
      chk({g.name, ".ctrl"},   {3'h0, ctrl},   {3'h0, g.ctrl});
      chk({g.name, ".chr0"},   {3'h0, chr0},   {3'h0, g.chr0});
      chk({g.name, ".chr1"},   {3'h0, chr1},   {3'h0, g.chr1});
      chk({g.name, ".prg"},    {3'h0, prg},    {3'h0, g.prg});
      chk({g.name, ".prg_nc"}, {3'h0, prg0},   {3'h0, g.prg0});
      if (g.same0) begin
         chk({g.name, ".prg_a_nc"},  {4'h0, prg_a0},  {4'h0, g.prg_a});
         chk({g.name, ".chr_a_nc"},  {3'h0, chr_a0},  {3'h0, g.chr_a});
         chk({g.name, ".cira10_nc"}, {7'h0, cira100}, {7'h0, g.cira});
         chk({g.name, ".ce_n_nc"},   {7'h0, ce_n0},   {7'h0, g.ce});
         chk({g.name, ".ctrl_nc"},   {3'h0, ctrl0},   {3'h0, g.ctrl});
         chk({g.name, ".chr0_nc"},   {3'h0, chr00},   {3'h0, g.chr0});
         chk({g.name, ".chr1_nc"},   {3'h0, chr10},   {3'h0, g.chr1});
      end
   endtask

   task automatic pulse_wr(input logic a14, input logic a13, input logic d7, input logic d0);
      cpu_a14 = a14; cpu_a13 = a13; cpu_d7 = d7; cpu_d0 = d0;
      cpu_wr = 1'b1; step(); cpu_wr = 1'b0; step();
   endtask

   task automatic pulse_end();
      cyc_end = 1'b1; step(); cyc_end = 1'b0; step();
   endtask

   // One write followed by an idle CPU cycle, so the next write is never consecutive
   task automatic wr(input logic a14, input logic a13, input logic d7, input logic d0);
      pulse_wr(a14, a13, d7, d0);
      pulse_end();
      pulse_end();
   endtask

   task automatic load(input logic a14, input logic a13, input logic [4:0] v);
      for (int i = 0; i < 5; i++) wr(a14, a13, 1'b0, v[i]);
   endtask

   task automatic set_ppu(input logic a14, input logic p10, input logic p11, input logic p12);
      cpu_a14 = a14; ppu_a10 = p10; ppu_a11 = p11; ppu_a12 = p12;
   endtask

   initial begin
      exp_t e;
      logic [4:0] pat;

      tbl[0] = '{5'h12, 5'h03, 5'h14, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 5'h03, 1'b1, 1'b0};
      tbl[1] = '{5'h12, 5'h03, 5'h14, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 5'h14, 1'b0, 1'b0};
      tbl[2] = '{5'h00, 5'h00, 5'h00, 5'h05, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 5'h01, 1'b0, 1'b0};
      tbl[3] = '{5'h00, 5'h00, 5'h00, 5'h05, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 5'h00, 1'b0, 1'b0};
      tbl[4] = '{5'h0D, 5'h17, 5'h0A, 5'h16, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 5'h17, 1'b1, 1'b1};
      tbl[5] = '{5'h0D, 5'h17, 5'h0A, 5'h16, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 5'h16, 1'b1, 1'b1};
      tbl[6] = '{5'h0B, 5'h00, 5'h00, 5'h09, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 5'h00, 1'b1, 1'b0};
      tbl[7] = '{5'h0B, 5'h00, 5'h00, 5'h09, 1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 5'h01, 1'b0, 1'b0};
      tbl[8] = '{5'h1E, 5'h0F, 5'h10, 5'h1F, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 5'h10, 1'b1, 1'b1};
      tbl[9] = '{5'h1E, 5'h0F, 5'h10, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 5'h0F, 1'b0, 1'b1};

      res = 1'b1; cpu_wr = 1'b0; cyc_end = 1'b0;
      cpu_a14 = 1'b0; cpu_a13 = 1'b0; cpu_d7 = 1'b0; cpu_d0 = 1'b0;
      ppu_a10 = 1'b0; ppu_a11 = 1'b0; ppu_a12 = 1'b0;
      step(); step();
      res = 1'b0;
      step();

      // Reset state
      set_ppu(1'b1, 1'b0, 1'b0, 1'b0);
      e = '{"reset", 4'hF, 5'h00, 1'b0, 1'b0, 5'h0C, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1};
      expect_out(e);

      // Reset mid-load (count=3) discards the partial bits, then load prg via $E000
      load(1'b0, 1'b0, 5'h00);
      for (int i = 0; i < 3; i++) wr(1'b1, 1'b1, 1'b0, 1'b1);
      #2 res = 1'b1;
      #3 res = 1'b0;
      step();
      pat = 5'b00110;
      load(1'b1, 1'b1, pat);
      set_ppu(1'b0, 1'b0, 1'b0, 1'b0);
      e = '{"midload_reset", 4'h6, 5'h00, 1'b0, 1'b0, 5'h0C, 5'h00, 5'h00, 5'h06, 5'h06, 1'b1};
      expect_out(e);

      // D7 write after two serial bits, the second one back-to-back with it
      load(1'b0, 1'b0, 5'h01);
      wr(1'b0, 1'b1, 1'b0, 1'b0);
      pulse_wr(1'b0, 1'b1, 1'b0, 1'b0);
      pulse_end();
      pulse_wr(1'b0, 1'b0, 1'b1, 1'b0);
      pulse_end();
      pulse_end();
      load(1'b1, 1'b0, 5'h1F);
      set_ppu(1'b1, 1'b0, 1'b0, 1'b0);
      e = '{"d7_reset", 4'hF, 5'h00, 1'b1, 1'b0, 5'h0D, 5'h00, 5'h1F, 5'h06, 5'h06, 1'b1};
      expect_out(e);

      // Consecutive-write rule: back-to-back writes d0=1,0 then four spaced writes 1,1,0,0
      res = 1'b1; step(); res = 1'b0; step();
      pulse_wr(1'b1, 1'b1, 1'b0, 1'b1);
      pulse_end();
      pulse_wr(1'b1, 1'b1, 1'b0, 1'b0);
      pulse_end();
      pulse_end();
      wr(1'b1, 1'b1, 1'b0, 1'b1);
      wr(1'b1, 1'b1, 1'b0, 1'b1);
      wr(1'b1, 1'b1, 1'b0, 1'b0);
      wr(1'b1, 1'b1, 1'b0, 1'b0);
      set_ppu(1'b0, 1'b0, 1'b0, 1'b0);
      e = '{"consecutive", 4'h7, 5'h00, 1'b0, 1'b0, 5'h0C, 5'h00, 5'h00, 5'h07, 5'h0D, 1'b0};
      expect_out(e);

      // Mapping vectors: reload the registers, then drive address lines
      res = 1'b1; step(); res = 1'b0; step();
      for (int k = 0; k < 10; k++) begin
         load(1'b0, 1'b1, tbl[k].chr0);
         load(1'b1, 1'b0, tbl[k].chr1);
         load(1'b1, 1'b1, tbl[k].prg);
         load(1'b0, 1'b0, tbl[k].ctrl);
         set_ppu(tbl[k].a14, tbl[k].p10, tbl[k].p11, tbl[k].p12);
         e.name  = $sformatf("vec%0d", k);
         e.prg_a = tbl[k].e_prg_a;
         e.chr_a = tbl[k].e_chr_a;
         e.cira  = tbl[k].e_cira;
         e.ce    = tbl[k].e_ce;
         e.ctrl  = tbl[k].ctrl;
         e.chr0  = tbl[k].chr0;
         e.chr1  = tbl[k].chr1;
         e.prg   = tbl[k].prg;
         e.prg0  = tbl[k].prg;
         e.same0 = 1'b1;
         expect_out(e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
